// File: rtl/next_ppv_latch.sv
// Two-entry in-order flit buffer that latches the next-node prefer-port vector chosen from look-ahead RC candidates.
// Push-to-out_valid latency is 1 cycle; in_ready drops only when both entries are full and never looks at out_ready.
module next_ppv_latch #(
   parameter int FLIT_W         = 64,
   parameter int NUM_PORT       = 5,
   parameter int PC_INDEX_WIDTH = 3
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [FLIT_W-1:0]           in_flit,
   input  logic [PC_INDEX_WIDTH-1:0]   in_indir,
   input  logic [PC_INDEX_WIDTH-1:0]   in_alloc_port,
   input  logic [4*NUM_PORT-1:0]       in_ppv_cand,
   input  logic [3:0]                  in_ltb_cand,
   input  logic [3:0]                  in_rtb_cand,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [FLIT_W-1:0]           out_flit,
   output logic [NUM_PORT-1:0]         out_ppv,
   output logic                        out_ltb,
   output logic                        out_rtb,
   output logic [PC_INDEX_WIDTH-1:0]   out_port,
   output logic                        sel_err,
   output logic [15:0]                 eject_cnt
);

   localparam logic [PC_INDEX_WIDTH-1:0] P_LOCAL = PC_INDEX_WIDTH'(4);

   logic [FLIT_W-1:0]         r_flit [2];
   logic [NUM_PORT-1:0]       r_ppv  [2];
   logic                      r_ltb  [2];
   logic                      r_rtb  [2];
   logic [PC_INDEX_WIDTH-1:0] r_port [2];
   logic                      r_wr_ptr;
   logic                      r_rd_ptr;
   logic [1:0]                r_count;
   logic                      r_sel_err;
   logic [15:0]               r_eject_cnt;

   logic                      w_push;
   logic                      w_pop;
   logic                      w_illegal;
   logic                      w_eject;
   logic [1:0]                w_k;
   logic [NUM_PORT-1:0]       w_ppv;
   logic                      w_ltb;
   logic                      w_rtb;

   assign in_ready  = (r_count < 2'd2) && !reset;
   assign out_valid = (r_count != 2'd0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   assign w_illegal = (in_indir > P_LOCAL) || (in_alloc_port > P_LOCAL);
   assign w_eject   = (in_alloc_port == P_LOCAL);

   // Candidate slices are ordered relative to the arrival direction; a local
   // injection has no arrival direction, so the allocated port indexes directly.
   always_comb begin
      w_k = 2'd0;
      if (in_indir == P_LOCAL)
         w_k = in_alloc_port[1:0];
      else
         w_k = in_alloc_port[1:0] - in_indir[1:0] - 2'd1;
   end

   always_comb begin
      w_ppv = '0;
      w_ltb = 1'b0;
      w_rtb = 1'b0;
      if (!w_illegal && !w_eject) begin
         w_ppv = in_ppv_cand[int'(w_k)*NUM_PORT +: NUM_PORT];
         w_ltb = in_ltb_cand[w_k];
         w_rtb = in_rtb_cand[w_k];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            r_flit[i] <= '0;
            r_ppv[i]  <= '0;
            r_ltb[i]  <= 1'b0;
            r_rtb[i]  <= 1'b0;
            r_port[i] <= '0;
         end
         r_wr_ptr    <= 1'b0;
         r_rd_ptr    <= 1'b0;
         r_count     <= 2'd0;
         r_sel_err   <= 1'b0;
         r_eject_cnt <= 16'd0;
      end else begin
         if (w_push) begin
            r_flit[r_wr_ptr] <= in_flit;
            r_ppv[r_wr_ptr]  <= w_ppv;
            r_ltb[r_wr_ptr]  <= w_ltb;
            r_rtb[r_wr_ptr]  <= w_rtb;
            r_port[r_wr_ptr] <= in_alloc_port;
            r_wr_ptr         <= ~r_wr_ptr;
            if (w_illegal)
               r_sel_err <= 1'b1;
            if (w_eject && r_eject_cnt != 16'hFFFF)
               r_eject_cnt <= r_eject_cnt + 16'd1;
         end
         if (w_pop)
            r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign out_flit  = r_flit[r_rd_ptr];
   assign out_ppv   = r_ppv[r_rd_ptr];
   assign out_ltb   = r_ltb[r_rd_ptr];
   assign out_rtb   = r_rtb[r_rd_ptr];
   assign out_port  = r_port[r_rd_ptr];
   assign sel_err   = r_sel_err;
   assign eject_cnt = r_eject_cnt;

endmodule

// File: tb/tb_next_ppv_latch.sv
// Directed bench for next_ppv_latch with hand-computed expectations.
module tb_next_ppv_latch;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_flit;
   logic [2:0]  in_indir;
   logic [2:0]  in_alloc_port;
   logic [19:0] in_ppv_cand;
   logic [3:0]  in_ltb_cand;
   logic [3:0]  in_rtb_cand;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_flit;
   logic [4:0]  out_ppv;
   logic        out_ltb;
   logic        out_rtb;
   logic [2:0]  out_port;
   logic        sel_err;
   logic [15:0] eject_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // slice3..slice0
   localparam logic [19:0] PPV = 20'b10000_01000_00100_00001;

   next_ppv_latch #(.FLIT_W(64), .NUM_PORT(5), .PC_INDEX_WIDTH(3)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
      .in_indir(in_indir), .in_alloc_port(in_alloc_port),
      .in_ppv_cand(in_ppv_cand), .in_ltb_cand(in_ltb_cand), .in_rtb_cand(in_rtb_cand),
      .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
      .out_ppv(out_ppv), .out_ltb(out_ltb), .out_rtb(out_rtb), .out_port(out_port),
      .sel_err(sel_err), .eject_cnt(eject_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [63:0] f, input logic [2:0] indir,
                        input logic [2:0] alloc, input logic [3:0] ltb, input logic [3:0] rtb);
      in_valid      = v;
      in_flit       = f;
      in_indir      = indir;
      in_alloc_port = alloc;
      in_ppv_cand   = PPV;
      in_ltb_cand   = ltb;
      in_rtb_cand   = rtb;
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      out_ready = 1'b0;
      drive(1'b0, 64'h0, 3'd0, 3'd0, 4'h0, 4'h0);
      cyc();
      cyc();
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_flit", out_flit, 64'h0);
      check("rst_out_ppv", out_ppv, 5'd0);
      check("rst_sel_err", sel_err, 1'b0);
      check("rst_eject_cnt", eject_cnt, 16'd0);
      reset = 1'b0;
      #1;
      check("rst_release_in_ready", in_ready, 1'b1);

      // indir N(1) -> alloc W(3): k = 1, slice1
      out_ready = 1'b1;
      drive(1'b1, 64'hA1, 3'd1, 3'd3, 4'b0010, 4'b0000);
      cyc();
      drive(1'b0, 64'h0, 3'd0, 3'd0, 4'h0, 4'h0);
      check("t1_out_valid", out_valid, 1'b1);
      check("t1_out_ppv", out_ppv, 5'b00100);
      check("t1_out_port", out_port, 3'd3);
      check("t1_out_flit", out_flit, 64'hA1);
      check("t1_out_ltb", out_ltb, 1'b1);
      check("t1_out_rtb", out_rtb, 1'b0);
      cyc();
      check("t1_drained", out_valid, 1'b0);

      // local injection, alloc 2 -> slice2
      out_ready = 1'b0;
      drive(1'b1, 64'hB2, 3'd4, 3'd2, 4'b0100, 4'b1011);
      cyc();
      drive(1'b0, 64'h0, 3'd0, 3'd0, 4'h0, 4'h0);
      check("t2_out_ppv", out_ppv, 5'b01000);
      check("t2_out_ltb", out_ltb, 1'b1);
      check("t2_out_rtb", out_rtb, 1'b0);
      out_ready = 1'b1;
      cyc();
      check("t2_drained", out_valid, 1'b0);

      // U-turn (alloc == indir) -> slice3, then eject with simultaneous push/pop
      drive(1'b1, 64'hC3, 3'd2, 3'd2, 4'b1000, 4'b1000);
      cyc();
      check("t3_uturn_ppv", out_ppv, 5'b10000);
      check("t3_uturn_ltb", out_ltb, 1'b1);
      check("t3_uturn_rtb", out_rtb, 1'b1);
      check("t3_eject_before", eject_cnt, 16'd0);
      drive(1'b1, 64'hD4, 3'd0, 3'd4, 4'hF, 4'hF);
      cyc();
      drive(1'b0, 64'h0, 3'd0, 3'd0, 4'h0, 4'h0);
      check("t3_pushpop_valid", out_valid, 1'b1);
      check("t3_pushpop_flit", out_flit, 64'hD4);
      check("t3_eject_ppv", out_ppv, 5'd0);
      check("t3_eject_ltb", out_ltb, 1'b0);
      check("t3_eject_port", out_port, 3'd4);
      check("t3_eject_cnt", eject_cnt, 16'd1);
      cyc();
      check("t3_drained", out_valid, 1'b0);
      cyc();
      check("t3_underflow_valid", out_valid, 1'b0);
      check("t3_underflow_ready", in_ready, 1'b1);

      // fill both entries with out_ready low
      out_ready = 1'b0;
      drive(1'b1, 64'hAAAA, 3'd0, 3'd1, 4'h0, 4'h0);
      cyc();
      drive(1'b1, 64'hBBBB, 3'd3, 3'd1, 4'h0, 4'h0);
      cyc();
      drive(1'b1, 64'hEEEE, 3'd0, 3'd0, 4'h0, 4'h0);
      check("t4_full_in_ready", in_ready, 1'b0);
      check("t4_full_flit", out_flit, 64'hAAAA);
      check("t4_full_ppv", out_ppv, 5'b00001);
      cyc();
      drive(1'b0, 64'h0, 3'd0, 3'd0, 4'h0, 4'h0);
      check("t4_hold_flit", out_flit, 64'hAAAA);
      check("t4_hold_in_ready", in_ready, 1'b0);
      out_ready = 1'b1;
      cyc();
      check("t4_second_flit", out_flit, 64'hBBBB);
      check("t4_second_ppv", out_ppv, 5'b00100);
      check("t4_ready_back", in_ready, 1'b1);
      cyc();
      check("t4_drained", out_valid, 1'b0);

      // illegal allocated port
      out_ready = 1'b0;
      check("t5_sel_err_pre", sel_err, 1'b0);
      drive(1'b1, 64'hF6, 3'd0, 3'd6, 4'hF, 4'hF);
      cyc();
      drive(1'b0, 64'h0, 3'd0, 3'd0, 4'h0, 4'h0);
      check("t5_ill_valid", out_valid, 1'b1);
      check("t5_ill_flit", out_flit, 64'hF6);
      check("t5_ill_ppv", out_ppv, 5'd0);
      check("t5_ill_ltb", out_ltb, 1'b0);
      check("t5_ill_rtb", out_rtb, 1'b0);
      check("t5_sel_err", sel_err, 1'b1);
      check("t5_eject_unchanged", eject_cnt, 16'd1);
      out_ready = 1'b1;
      cyc();
      cyc();
      check("t5_sel_err_sticky", sel_err, 1'b1);

      // two ejects fill the buffer, then reset with push and pop pending
      out_ready = 1'b0;
      drive(1'b1, 64'h11, 3'd4, 3'd4, 4'h0, 4'h0);
      cyc();
      drive(1'b1, 64'h22, 3'd1, 3'd4, 4'h0, 4'h0);
      cyc();
      check("t6_full_in_ready", in_ready, 1'b0);
      check("t6_eject_cnt", eject_cnt, 16'd3);
      reset     = 1'b1;
      out_ready = 1'b1;
      #1;
      check("t6_rst_in_ready", in_ready, 1'b0);
      cyc();
      check("t6_rst_out_valid", out_valid, 1'b0);
      check("t6_rst_eject_cnt", eject_cnt, 16'd0);
      check("t6_rst_sel_err", sel_err, 1'b0);
      check("t6_rst_out_flit", out_flit, 64'h0);
      check("t6_rst_out_port", out_port, 3'd0);
      check("t6_rst_hold_in_ready", in_ready, 1'b0);
      cyc();
      check("t6_rst_priority_valid", out_valid, 1'b0);
      drive(1'b0, 64'h0, 3'd0, 3'd0, 4'h0, 4'h0);
      reset = 1'b0;
      #1;
      check("t6_release_in_ready", in_ready, 1'b1);
      cyc();
      check("t6_post_valid", out_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
